// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: execute-to-memory/writeback handshake bundle.
//   master (execute side): drives in_valid and the instruction fields, sees in_ready.
//   slave  (stage side)  : sees in_valid and the instruction fields, drives in_ready.
//   Fields: in_dest (register index), in_result (ALU/LOADC value), in_write_en,
//           in_read (load), in_write (store), in_address, in_data_out (store data),
//           in_halt.
interface mem_wb_stage_if #(
    parameter int D_BITS = 32,
    parameter int A_BITS = 10,
    parameter int R_BITS = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [R_BITS-1:0] in_dest;
    logic [D_BITS-1:0] in_result;
    logic              in_write_en;
    logic              in_read;
    logic              in_write;
    logic [A_BITS-1:0] in_address;
    logic [D_BITS-1:0] in_data_out;
    logic              in_halt;

    modport master (
        output in_valid, in_dest, in_result, in_write_en, in_read, in_write,
               in_address, in_data_out, in_halt,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_dest, in_result, in_write_en, in_read, in_write,
               in_address, in_data_out, in_halt,
        output in_ready
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback stage with variable-latency data-memory access.
//   clk, rst_n         : rising-edge clock, asynchronous active-low reset
//   ex (slave)         : execute handshake; one instruction per in_valid & in_ready
//   mem_addr/mem_wdata : held address/store data while a request is outstanding
//   mem_rd/mem_wr      : request levels, dropped the cycle after mem_ack is sampled
//   mem_ack/mem_rdata  : completion strobe and load data
//   rf_we/rf_waddr/rf_wdata : one-cycle register-file write; addr/data hold otherwise
//   halted             : sticky halt flag, cleared only by reset
module mem_wb_stage #(
    parameter int D_BITS = 32,
    parameter int A_BITS = 10,
    parameter int R_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_wb_stage_if.slave     ex,
    output logic [A_BITS-1:0] mem_addr,
    output logic [D_BITS-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack,
    input  logic [D_BITS-1:0] mem_rdata,
    output logic              rf_we,
    output logic [R_BITS-1:0] rf_waddr,
    output logic [D_BITS-1:0] rf_wdata,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, MEM, HALT} state_t;

    state_t            state, state_d;
    logic [R_BITS-1:0] ld_dest, ld_dest_d;
    logic [A_BITS-1:0] mem_addr_d;
    logic [D_BITS-1:0] mem_wdata_d;
    logic              mem_rd_d, mem_wr_d;
    logic              rf_we_d;
    logic [R_BITS-1:0] rf_waddr_d;
    logic [D_BITS-1:0] rf_wdata_d;
    logic              halted_d;
    logic              fire;

    assign ex.in_ready = (state == IDLE);
    assign fire        = ex.in_valid & ex.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ld_dest   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_d;
            ld_dest   <= ld_dest_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            rf_we     <= rf_we_d;
            rf_waddr  <= rf_waddr_d;
            rf_wdata  <= rf_wdata_d;
            halted    <= halted_d;
        end
    end

    always_comb begin
        state_d     = state;
        ld_dest_d   = ld_dest;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_rd_d    = mem_rd;
        mem_wr_d    = mem_wr;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr;
        rf_wdata_d  = rf_wdata;
        halted_d    = halted;
        case (state)
            IDLE: begin
                if (fire) begin
                    // halt > read > write > write_en; a load always writes back
                    // to in_dest, so write_en is irrelevant for memory ops
                    if (ex.in_halt) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else if (ex.in_read) begin
                        state_d    = MEM;
                        ld_dest_d  = ex.in_dest;
                        mem_addr_d = ex.in_address;
                        mem_rd_d   = 1'b1;
                    end else if (ex.in_write) begin
                        state_d     = MEM;
                        mem_addr_d  = ex.in_address;
                        mem_wdata_d = ex.in_data_out;
                        mem_wr_d    = 1'b1;
                    end else if (ex.in_write_en) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ex.in_dest;
                        rf_wdata_d = ex.in_result;
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    // mem_rd still high here identifies the access as a load
                    if (mem_rd) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ld_dest;
                        rf_wdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/writeback stage that sits directly downstream of the execute unit. It registers one execute result per handshake, runs data-memory loads and stores over a variable-latency request/ack interface, and writes ALU and load results back to the register file. It back-pressures execute while a memory access is outstanding, and latches the processor halt.

## Interface
Parameters:
- D_BITS, 32, data width
- A_BITS, 10, data-memory address width
- R_BITS, 3, register-file index width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute presents an instruction this cycle
- in_ready  output  1  stage accepts; transfer occurs when in_valid & in_ready
- in_dest  input  R_BITS  destination register index
- in_result  input  D_BITS  ALU / LOADC result
- in_write_en  input  1  write in_result to in_dest
- in_read  input  1  load from in_address
- in_write  input  1  store in_data_out to in_address
- in_address  input  A_BITS  memory address
- in_data_out  input  D_BITS  store data
- in_halt  input  1  halt instruction
- mem_addr  output  A_BITS  memory address, held during request
- mem_wdata  output  D_BITS  store data, held during request
- mem_rd  output  1  read request level
- mem_wr  output  1  write request level
- mem_ack  input  1  memory completes the current request this cycle
- mem_rdata  input  D_BITS  load data, valid when mem_ack=1
- rf_we  output  1  register-file write strobe (one-cycle pulse)
- rf_waddr  output  R_BITS  write index
- rf_wdata  output  D_BITS  write data
- halted  output  1  processor halted (sticky)

## Operation
- FSM states: IDLE, MEM, HALT. `in_ready = (state == IDLE)`.
- All other outputs are registered.
- **IDLE, transfer accepted.** Decode priority is `in_halt` > `in_read` > `in_write` > `in_write_en`. The first match applies:
  - Halt: go to HALT. Set `halted=1`. No writeback and no memory access.
  - Read: capture `in_dest` and `in_address`. Assert `mem_rd` next cycle. Go to MEM.
  - Write: capture `in_address` and `in_data_out`. Assert `mem_wr` next cycle. Go to MEM.
  - write_en: pulse `rf_we` next cycle with `rf_waddr=in_dest` and `rf_wdata=in_result`. Stay in IDLE.
  - None set (jump, nop): no action.
- **Conflicting flags.** If `in_read` and `in_write` are both 1, the load wins and the store is dropped. `in_write_en` with `in_read` or `in_write` is ignored; a load always writes back to `in_dest`.
- **MEM state.**
  - `mem_addr`, `mem_wdata`, `mem_rd` and `mem_wr` stay stable until `mem_ack` is sampled high.
  - On ack: drop `mem_rd`/`mem_wr` next cycle and return to IDLE.
  - If the access was a load: pulse `rf_we` next cycle with `rf_wdata=mem_rdata` as sampled at the ack.
  - A store produces no register write.
- **Ignored inputs.** `mem_ack` in IDLE or HALT is ignored. `in_valid` outside IDLE is ignored, because no transfer can occur.
- **HALT.** Terminal. `in_ready=0`, `halted=1`, memory requests are 0, `rf_we=0`. Only reset exits.
- **rf_waddr / rf_wdata.** These hold their last value when `rf_we=0`.

## Timing
- **Reset (asynchronous, immediate).**
  - State returns to IDLE.
  - `mem_rd`, `mem_wr`, `rf_we` and `halted` go to 0.
  - `mem_addr`, `mem_wdata`, `rf_waddr` and `rf_wdata` go to 0.
  - `in_ready=1` after reset deasserts.
  - A reset during MEM abandons the access: requests drop in the same instant, no writeback follows, and any later `mem_ack` is ignored.
- **ALU op.**
  - Accepted at edge N, so `rf_we=1` in cycle N+1.
  - Back-to-back ALU ops sustain one per cycle.
- **Load/store.**
  - Accepted at edge N, so the request is high from cycle N+1.
  - `mem_ack` may be high as early as cycle N+1. Ack sampled at edge M gives: request low, `in_ready=1`, and (load only) `rf_we=1`, all in cycle M+1.
  - Minimum occupancy is 2 cycles.
- **Halt.** Accepted at edge N, so `halted=1` and `in_ready=0` from cycle N+1.
- **Write/read ordering.** No register-file forwarding. An `rf_we` pulse in cycle K is written at the end of K.

## Test plan
- **Reset.** Assert rst_n=0 mid-cycle during a MEM load.
  - Outputs must go to 0 immediately and `in_ready` must be 1 after release.
  - An ack arriving later must produce no `rf_we`.
- **ALU stream.** 3 back-to-back ALU ops, dest 1/2/3, results 0x11/0x22/0x33, `in_write_en=1`.
  - `rf_we` must be high for 3 consecutive cycles with matching addr/data.
  - `in_ready` must stay 1 throughout.
- **Load, delayed ack.** Load dest 5, addr 0x3FF. Ack after 4 cycles with `mem_rdata=0xDEADBEEF`.
  - `mem_rd` and `mem_addr=0x3FF` must hold for 4 cycles.
  - Next cycle: `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`, `in_ready=1`.
- **Store, immediate ack.** Store 0xCAFE0001 to addr 0x010, ack in the first request cycle.
  - `mem_wr` must be high for exactly 1 cycle with correct addr/data.
  - There must be no `rf_we`.
  - An ALU op presented in the next cycle is accepted.
- **Back-pressure.** Hold `in_valid=1` with a new ALU op during a load wait.
  - The op must not be consumed until `in_ready=1`.
  - It is then written back exactly once, one cycle after the load's writeback.
- **Halt.** Halt followed by a valid ALU op.
  - `halted=1` from the next cycle.
  - There must be no `rf_we` and no memory request, and `in_ready` stays 0 until reset.
